// File: rtl/crc_ahb_pkg.sv
// crc_ahb_pkg: command codes, CRC-32/IEEE constants, FSM states and byte-wide CRC step
package crc_ahb_pkg;
  localparam logic [7:0] CMD_INIT = 8'h49;
  localparam logic [7:0] CMD_DATA = 8'h44;
  localparam logic [7:0] CMD_READ = 8'h52;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_XOROUT = 32'hFFFFFFFF;
  typedef enum logic [1:0] {IDLE, LEN, DATA, REPLY} state_t;
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) c = (c >> 1) ^ (CRC_POLY & {32{c[0] ^ data[i]}});
    return c;
  endfunction
endpackage

// File: rtl/uart_8n1.sv
// uart_8n1: 8N1 receiver with glitch-rejecting start check and back-to-back capable transmitter
module uart_8n1 #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       txd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  logic [2:0] rx_sync;
  logic rx_busy;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [3:0] rx_bit, tx_left;
  logic [9:0] tx_sh;
  // rx_bit 0 is the start-bit half-bit check, 1..8 data, 9 stop
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_sync <= '1;
      rx_busy <= 1'b0;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[1:0], rxd};
      rx_valid <= 1'b0;
      if (!rx_busy) begin
        rx_busy <= rx_sync[2] & ~rx_sync[1];
        rx_cnt <= '0;
        rx_bit <= '0;
      end else if (rx_cnt != (rx_bit == 4'd0 ? HALF_END : BIT_END)) rx_cnt <= rx_cnt + 1'b1;
      else begin
        rx_cnt <= '0;
        rx_bit <= rx_bit + 1'b1;
        if (rx_bit == 4'd0) rx_busy <= ~rx_sync[1];
        else if (rx_bit == 4'd9) begin
          rx_busy <= 1'b0;
          rx_valid <= rx_sync[1];
        end else rx_data <= {rx_sync[1], rx_data[7:1]};
      end
    end
  // busy drops on the final stop-bit cycle so a queued byte starts with no gap
  assign tx_busy = (tx_left != 4'd0) && !(tx_left == 4'd1 && tx_cnt == BIT_END);
  assign txd = tx_sh[0];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_sh <= '1;
      tx_left <= '0;
      tx_cnt <= '0;
    end else if (tx_start && !tx_busy) begin
      tx_sh <= {1'b1, tx_data, 1'b0};
      tx_left <= 4'd10;
      tx_cnt <= '0;
    end else if (tx_left != 4'd0) begin
      if (tx_cnt == BIT_END) begin
        tx_cnt <= '0;
        tx_left <= tx_left - 1'b1;
        tx_sh <= {1'b1, tx_sh[9:1]};
      end else tx_cnt <= tx_cnt + 1'b1;
    end
endmodule

// File: rtl/crc_ahb_ip_core.sv
// crc_ahb_ip_core: UART command FSM driving a CRC-32/IEEE accumulator
module crc_ahb_ip_core import crc_ahb_pkg::*; #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic SYSCLK,
  input  logic SYSRESET,
  input  logic UART_0_RXD,
  output logic UART_0_TXD
);
  state_t state, nstate;
  logic [31:0] crc, ncrc, crc_out;
  logic [7:0] cnt, ncnt, rx_data, tx_data;
  logic [1:0] ridx, nridx;
  logic rx_valid, tx_start, tx_busy;
  uart_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk(SYSCLK),
    .rst(SYSRESET),
    .rxd(UART_0_RXD),
    .txd(UART_0_TXD),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .tx_busy(tx_busy)
  );
  assign crc_out = crc ^ CRC_XOROUT;
  always_ff @(posedge SYSCLK or posedge SYSRESET)
    if (SYSRESET) begin
      state <= IDLE;
      crc <= CRC_INIT;
      cnt <= '0;
      ridx <= '0;
    end else begin
      state <= nstate;
      crc <= ncrc;
      cnt <= ncnt;
      ridx <= nridx;
    end
  // count 0 means 256: decrementing from 0 wraps to 255 and ends at 1
  always_comb begin
    nstate = state;
    ncrc = crc;
    ncnt = cnt;
    nridx = ridx;
    tx_start = 1'b0;
    tx_data = ACK;
    case (state)
      IDLE:
        if (rx_valid && !tx_busy) begin
          tx_start = rx_data != CMD_DATA;
          if (rx_data == CMD_INIT) ncrc = CRC_INIT;
          else if (rx_data == CMD_DATA) nstate = LEN;
          else if (rx_data == CMD_READ) begin
            tx_data = crc_out[7:0];
            nridx = 2'd1;
            nstate = REPLY;
          end else tx_data = NAK;
        end
      LEN:
        if (rx_valid) begin
          ncnt = rx_data;
          nstate = DATA;
        end
      DATA:
        if (rx_valid) begin
          ncrc = crc32_byte(crc, rx_data);
          ncnt = cnt - 8'd1;
          tx_start = cnt == 8'd1;
          nstate = cnt == 8'd1 ? IDLE : DATA;
        end
      REPLY: begin
        tx_start = 1'b1;
        tx_data = crc_out[{ridx, 3'b000} +: 8];
        if (!tx_busy) begin
          nridx = ridx + 2'd1;
          nstate = ridx == 2'd3 ? IDLE : REPLY;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_crc_ahb_ip_core.sv
// tb_crc_ahb_ip_core: directed UART stimulus with an expected-byte scoreboard on the TX line
module tb_crc_ahb_ip_core;
  localparam int CPB = 16;
  logic SYSCLK = 1'b0;
  logic SYSRESET = 1'b1;
  logic UART_0_RXD = 1'b1;
  logic UART_0_TXD;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int tx_t[$];
  logic mon_en = 1'b0;
  logic mon_busy = 1'b0;
  crc_ahb_ip_core #(.CLKS_PER_BIT(CPB)) dut (
    .SYSCLK(SYSCLK),
    .SYSRESET(SYSRESET),
    .UART_0_RXD(UART_0_RXD),
    .UART_0_TXD(UART_0_TXD)
  );
  always #5 SYSCLK = ~SYSCLK;
  always @(posedge SYSCLK) cyc++;
  function automatic logic [31:0] model_crc(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] x;
    x = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) x = x[0] ? (x >> 1) ^ 32'hEDB88320 : x >> 1;
    return x;
  endfunction
  always begin : mon
    logic [7:0] b;
    logic stp;
    logic [7:0] e;
    @(negedge UART_0_TXD);
    mon_busy = 1'b1;
    tx_t.push_back(cyc);
    repeat (CPB / 2) @(negedge SYSCLK);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge SYSCLK);
      b[i] = UART_0_TXD;
    end
    repeat (CPB) @(negedge SYSCLK);
    stp = UART_0_TXD;
    if (mon_en) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_byte: got %h expected no output", b);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        assert ({stp, b} === {1'b1, e}) else begin
          errors++;
          $error("FAIL tx_byte: got %h stop %b expected %h stop 1", b, stp, e);
        end
      end
    end
    mon_busy = 1'b0;
  end
  task automatic send(input logic [7:0] b, input logic stp = 1'b1);
    logic [9:0] f;
    f = {stp, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      UART_0_RXD = f[i];
      repeat (CPB) @(negedge SYSCLK);
    end
    UART_0_RXD = 1'b1;
  endtask
  task automatic quiet(input int n);
    repeat (n) @(negedge SYSCLK);
  endtask
  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 60 * CPB) begin
      @(negedge SYSCLK);
      n++;
    end
    checks++;
    assert (n < 60 * CPB) else begin
      errors++;
      $error("FAIL drain: got %0d bytes outstanding expected 0", exp_q.size());
    end
    quiet(4);
  endtask
  task automatic span_check();
    int d;
    d = (tx_t.size() == 4) ? tx_t[3] - tx_t[0] : -1;
    checks++;
    assert (d === 30 * CPB) else begin
      errors++;
      $error("FAIL reply_span: got %0d cycles over %0d starts expected %0d over 4", d, tx_t.size(), 30 * CPB);
    end
  endtask
  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(w >> (8 * k)));
  endtask
  initial begin
    logic [31:0] r;
    int n;
    int target;
    repeat (10) begin
      @(negedge SYSCLK);
      checks++;
      assert (UART_0_TXD === 1'b1) else begin
        errors++;
        $error("FAIL reset_txd: got %b expected 1", UART_0_TXD);
      end
    end
    SYSRESET = 1'b0;
    mon_en = 1'b1;
    quiet(2 * CPB);
    exp_q.push_back(8'h06);
    send(8'h49);
    drain();
    exp_q.push_back(8'h06);
    send(8'h44);
    send(8'h09);
    for (int i = 0; i < 9; i++) send(8'h31 + 8'(i));
    drain();
    tx_t.delete();
    push_word(32'hCBF43926);
    send(8'h52);
    drain();
    span_check();
    exp_q.push_back(8'h06);
    send(8'h49);
    drain();
    for (int k = 0; k < 2; k++) begin
      tx_t.delete();
      push_word(32'h0);
      send(8'h52);
      drain();
      span_check();
    end
    exp_q.push_back(8'h15);
    send(8'h7A);
    drain();
    exp_q.push_back(8'h06);
    send(8'h44);
    send(8'h01);
    send(8'h52);
    drain();
    quiet(15 * CPB);
    UART_0_RXD = 1'b0;
    quiet(CPB / 4);
    UART_0_RXD = 1'b1;
    quiet(12 * CPB);
    send(8'h49, 1'b0);
    quiet(12 * CPB);
    r = model_crc(32'hFFFFFFFF, 8'h52) ^ 32'hFFFFFFFF;
    tx_t.delete();
    push_word(r);
    send(8'h52);
    drain();
    span_check();
    mon_en = 1'b0;
    tx_t.delete();
    send(8'h52);
    n = 0;
    while (tx_t.size() == 0 && n < 20 * CPB) begin
      @(negedge SYSCLK);
      n++;
    end
    checks++;
    assert (tx_t.size() != 0) else begin
      errors++;
      $error("FAIL reply_start: got no start bit expected one within %0d cycles", 20 * CPB);
    end
    target = (tx_t.size() != 0) ? tx_t[0] + 10 * CPB + CPB / 2 : 0;
    n = 0;
    while (cyc < target && n < 40 * CPB) begin
      @(negedge SYSCLK);
      n++;
    end
    checks++;
    assert (UART_0_TXD === 1'b0) else begin
      errors++;
      $error("FAIL second_start_bit: got %b expected 0", UART_0_TXD);
    end
    #1 SYSRESET = 1'b1;
    #1;
    checks++;
    assert (UART_0_TXD === 1'b1) else begin
      errors++;
      $error("FAIL reset_truncate: got %b expected 1", UART_0_TXD);
    end
    quiet(3);
    SYSRESET = 1'b0;
    quiet(12 * CPB);
    exp_q.delete();
    tx_t.delete();
    mon_en = 1'b1;
    push_word(32'h0);
    send(8'h52);
    drain();
    span_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/crc_ahb_ip_core.md
# crc_ahb_ip_core

UART-attached CRC-32 accelerator: core logic of the crc_ahb_ip SoC subsystem. A host streams commands and data bytes over a single 8N1 serial line. The block folds data bytes into a CRC-32/IEEE accumulator and returns acknowledgements or the finished checksum on the transmit line.

## Interface
- CLKS_PER_BIT, default 87 — SYSCLK cycles per UART bit (10 MHz / 115200 baud).
- SYSCLK  in  1 — system clock, 10 MHz nominal.
- SYSRESET  in  1 — one clock; reset is asynchronous and active-high.
- UART_0_RXD  in  1 — serial input, 8N1, LSB first, idle high; asynchronous to SYSCLK.
- UART_0_TXD  out  1 — serial output, 8N1, LSB first, idle high.

## Operation
- **RX path**
  - 2-flop synchronizer on UART_0_RXD.
  - A falling edge starts a frame; the start bit is re-checked at the half-bit point, and a high there aborts the frame (glitch reject).
  - Data bits are sampled at mid-bit. The stop bit is sampled at mid-bit; 0 = framing error, byte discarded.
- **TX path**: start bit, 8 data bits LSB first, one stop bit, each exactly CLKS_PER_BIT cycles.
- **Command FSM states**: IDLE, LEN, DATA, REPLY.
  - IDLE, 0x49 'I': CRC := 0xFFFFFFFF, send ACK 0x06.
  - IDLE, 0x44 'D': go to LEN. The next byte is the count N, where 0 means 256. Go to DATA.
  - DATA: each byte (any value) updates the CRC and decrements the count. After the last byte, send ACK and return to IDLE.
  - IDLE, 0x52 'R': enter REPLY. Send the 4 bytes of (CRC XOR 0xFFFFFFFF), LSB first, then return to IDLE. The accumulator is not modified, so repeated 'R' gives the same result.
  - IDLE, any other byte: send NAK 0x15.
  - Bytes received while in REPLY, or while an ACK/NAK is still transmitting, are dropped.
- **CRC update**
  - Reflected poly 0xEDB88320, one full byte per SYSCLK, computed as 8 unrolled shift/xor steps.
  - crc = (crc >> 1) ^ (poly & {32{crc[0] ^ d}}), with d = data bit i and bits taken LSB first.
- Framing-error bytes have no effect in any state: count, CRC and state are all unchanged.

## Timing
- **Reset values**: UART_0_TXD = 1, FSM = IDLE, CRC = 0xFFFFFFFF, count = 0, RX/TX idle.
- Reset applies immediately on assertion, mid-frame included.
- A TX frame in progress at reset is truncated, and the line returns high at once.
- **RX valid pulse**: 1 cycle, asserted at the stop-bit mid-sample.
- **CRC latency**: the accumulator holds the updated value on the cycle after the valid pulse.
- **Response latency**: the start bit of an ACK/NAK/first 'R' byte begins ≤2 SYSCLK after the triggering byte's valid pulse.
- **'R' reply framing**: consecutive bytes back-to-back, no idle gap between stop and next start.
- **Frame length**: one byte = 10×CLKS_PER_BIT cycles.
- RX accepts a new start bit immediately after the stop-bit sample point, so back-to-back frames are supported.
- The last DATA byte's ACK and its CRC update take effect on the same cycle.

## Structure
- **Package crc_ahb_pkg**:
  - Command codes 0x49/0x44/0x52; ACK 0x06, NAK 0x15.
  - CRC_POLY, CRC_INIT, CRC_XOROUT.
  - FSM state enum.
  - Function crc32_byte(crc, data).
- **Sub-module uart_8n1**: RX and TX engines parameterised by CLKS_PER_BIT. It exposes rx_data/rx_valid and tx_data/tx_start/tx_busy.
- **Top level**: the command FSM, CRC register and count register live here.

## Test plan
- Reset held 10 cycles with RXD high → TXD stays 1 throughout; no frames emitted.
- Send 'I', 'D', 0x09, "123456789", 'R' → ACK, ACK, then bytes 0x26 0x39 0xF4 0xCB (CRC 0xCBF43926).
- Send 'I', 'R' → ACK, then 0x00 0x00 0x00 0x00; a second 'R' repeats the same bytes.
- Send 0x7A in IDLE → NAK 0x15. Send 'D', 0x01, 0x52 → ACK only; 0x52 is hashed as data, not treated as 'R'.
- 1/4-bit low glitch on RXD, and a frame with stop bit 0 → no response, CRC unchanged. A following 'R' gives the same value as before.
- Assert SYSRESET mid-way through the 2nd reply byte of 'R' → TXD high within the reset edge. After release, 'R' returns 0x00000000 (CRC reinitialised).
